// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 6-digit 7-segment scan into BCD digits with blink tracking
// Ports: clk_100MHz/rst_time clock and async active-low reset; bit_sel/seg_sel scanned digit
// enables and segment code (active-low); L_sec..H_hour decoded digits; frame_done pulses on the
// H_hour slot; blink_field names the blanked field (3 = none); code_err/sel_err flag bad input.
module seg_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int HOLD_FRAMES = 64
) (
  input  logic       clk_100MHz,
  input  logic       rst_time,
  input  logic [7:0] bit_sel,
  input  logic [6:0] seg_sel,
  output logic [3:0] L_sec,
  output logic [3:0] H_sec,
  output logic [3:0] L_min,
  output logic [3:0] H_min,
  output logic [3:0] L_hour,
  output logic [3:0] H_hour,
  output logic       frame_done,
  output logic [1:0] blink_field,
  output logic       code_err,
  output logic       sel_err
);
  localparam logic [1:0] IDLE = 2'd0, SETTLING = 2'd1, CAPTURED = 2'd2;
  logic [7:0] bs_q, bs_p;
  logic [6:0] ss_q, ss_p;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [2:0] ptr, idx, slot;
  logic [7:0] hold;
  logic [3:0] dig [6];
  logic [3:0] val;
  logic change, accept, is_digit, is_blank, legal;
  assign change = {bs_q, ss_q} != {bs_p, ss_p};
  assign accept = state == SETTLING && !change && cnt == 4'(SETTLE - 1);
  assign is_blank = bs_q == 8'hFF;
  assign is_digit = bs_q[7:6] == 2'b11 && $onehot(~bs_q[5:0]);
  // a blank carries no index of its own, so it takes the slot the scan should be on
  assign slot = is_digit ? idx : ptr;
  assign {H_hour, L_hour, H_min, L_min, H_sec, L_sec} = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 6; i++) if (!bs_q[i]) idx = 3'(i);
  end
  always_comb begin
    legal = 1'b1;
    val = 4'd0;
    case (ss_q)
      7'b1000000: val = 4'd0;
      7'b1111001: val = 4'd1;
      7'b0100100: val = 4'd2;
      7'b0110000: val = 4'd3;
      7'b0011001: val = 4'd4;
      7'b0010010: val = 4'd5;
      7'b0000010: val = 4'd6;
      7'b1111000: val = 4'd7;
      7'b0000000: val = 4'd8;
      7'b0010000: val = 4'd9;
      default:    legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk_100MHz or negedge rst_time) begin
    if (!rst_time) begin
      bs_q <= 8'hFF;
      bs_p <= 8'hFF;
      ss_q <= 7'h7F;
      ss_p <= 7'h7F;
      state <= IDLE;
      cnt <= 4'd0;
      ptr <= 3'd0;
      hold <= 8'd0;
      blink_field <= 2'd3;
      frame_done <= 1'b0;
      code_err <= 1'b0;
      sel_err <= 1'b0;
      for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
    end else begin
      bs_q <= bit_sel;
      ss_q <= seg_sel;
      bs_p <= bs_q;
      ss_p <= ss_q;
      frame_done <= 1'b0;
      code_err <= 1'b0;
      sel_err <= 1'b0;
      if (change) begin
        state <= SETTLING;
        cnt <= 4'd1;
      end else if (state == SETTLING) begin
        cnt <= cnt + 4'd1;
        if (accept) state <= CAPTURED;
      end
      if (accept) begin
        if (is_digit || is_blank) begin
          ptr <= slot == 3'd5 ? 3'd0 : slot + 3'd1;
          frame_done <= slot == 3'd5;
          code_err <= is_digit && !legal;
          if (is_digit && legal) dig[idx] <= val;
          if (is_blank) begin
            blink_field <= slot[2:1];
            hold <= 8'(HOLD_FRAMES);
          end else if (slot == 3'd5 && hold != 8'd0) begin
            hold <= hold - 8'd1;
            if (hold == 8'd1) blink_field <= 2'd3;
          end
        end else sel_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;
  localparam int HOLD_FRAMES = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] bit_sel = 8'hFF;
  logic [6:0] seg_sel = 7'h7F;
  logic [3:0] L_sec, H_sec, L_min, H_min, L_hour, H_hour;
  logic frame_done, code_err, sel_err;
  logic [1:0] blink_field;
  int n_vec = 0, n_err = 0;
  int fd_n = 0, ce_n = 0, se_n = 0;
  int fd0, ce0, se0;
  logic [6:0] seg_of [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  wire [23:0] digits = {H_hour, L_hour, H_min, L_min, H_sec, L_sec};
  seg_scan_decoder #(.SETTLE(SETTLE), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .clk_100MHz(clk), .rst_time(rst_n), .bit_sel(bit_sel), .seg_sel(seg_sel),
    .L_sec(L_sec), .H_sec(H_sec), .L_min(L_min), .H_min(H_min), .L_hour(L_hour), .H_hour(H_hour),
    .frame_done(frame_done), .blink_field(blink_field), .code_err(code_err), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) fd_n++;
    if (code_err) ce_n++;
    if (sel_err) se_n++;
  end
  task automatic present(input logic [7:0] b, input logic [6:0] s, input int n);
    bit_sel = b;
    seg_sel = s;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic show(input int i, input int d, input int n);
    present(~(8'h01 << i), seg_of[d], n);
  endtask
  task automatic snap;
    fd0 = fd_n;
    ce0 = ce_n;
    se0 = se_n;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (digits !== 24'h0) begin n_err++; $display("FAIL reset_digits: got %h expected %h", digits, 24'h0); end
    n_vec++; if (blink_field !== 2'd3) begin n_err++; $display("FAIL reset_blink: got %0d expected 3", blink_field); end
    n_vec++; if ({frame_done, code_err, sel_err} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b expected 000", {frame_done, code_err, sel_err}); end
    rst_n = 1'b1;
    present(8'hFF, 7'h7F, 4);
  endtask
  task automatic test_scan;
    int vals [6] = '{3, 2, 1, 4, 5, 1};
    snap();
    for (int i = 0; i < 6; i++) show(i, vals[i], 100);
    n_vec++; if (digits !== 24'h154123) begin n_err++; $display("FAIL scan_digits: got %h expected %h", digits, 24'h154123); end
    n_vec++; if (fd_n - fd0 !== 1) begin n_err++; $display("FAIL scan_frame_done: got %0d expected 1", fd_n - fd0); end
    n_vec++; if (ce_n - ce0 + se_n - se0 !== 0) begin n_err++; $display("FAIL scan_errors: got %0d expected 0", ce_n - ce0 + se_n - se0); end
  endtask
  task automatic test_glitch;
    snap();
    show(0, 6, 20);
    show(1, 9, SETTLE - 1);
    show(0, 6, 20);
    n_vec++; if (digits !== 24'h154126) begin n_err++; $display("FAIL glitch_ignored: got %h expected %h", digits, 24'h154126); end
    show(1, 7, 20);
    n_vec++; if (digits !== 24'h154176) begin n_err++; $display("FAIL glitch_next: got %h expected %h", digits, 24'h154176); end
    n_vec++; if (ce_n - ce0 + se_n - se0 !== 0) begin n_err++; $display("FAIL glitch_errors: got %0d expected 0", ce_n - ce0 + se_n - se0); end
  endtask
  task automatic test_errors;
    snap();
    present(8'b11111100, seg_of[1], 50);
    n_vec++; if (se_n - se0 !== 1) begin n_err++; $display("FAIL sel_err_pulses: got %0d expected 1", se_n - se0); end
    n_vec++; if (digits !== 24'h154176) begin n_err++; $display("FAIL sel_err_digits: got %h expected %h", digits, 24'h154176); end
    present(8'hFE, 7'h7F, 50);
    n_vec++; if (ce_n - ce0 !== 1) begin n_err++; $display("FAIL code_err_pulses: got %0d expected 1", ce_n - ce0); end
    n_vec++; if (L_sec !== 4'd6) begin n_err++; $display("FAIL code_err_lsec: got %0d expected 6", L_sec); end
  endtask
  task automatic test_blink;
    show(0, 8, 8);
    show(1, 9, 8);
    present(8'hFF, 7'h7F, 16);
    n_vec++; if (blink_field !== 2'd1) begin n_err++; $display("FAIL blink_set: got %0d expected 1", blink_field); end
    show(4, 2, 8);
    show(5, 3, 8);
    n_vec++; if (digits !== 24'h324198) begin n_err++; $display("FAIL blink_min_kept: got %h expected %h", digits, 24'h324198); end
    for (int f = 0; f < HOLD_FRAMES - 2; f++) for (int i = 0; i < 6; i++) show(i, i, 8);
    n_vec++; if (blink_field !== 2'd1) begin n_err++; $display("FAIL blink_held: got %0d expected 1", blink_field); end
    for (int f = 0; f < 2; f++) for (int i = 0; i < 6; i++) show(i, i, 8);
    n_vec++; if (blink_field !== 2'd3) begin n_err++; $display("FAIL blink_expired: got %0d expected 3", blink_field); end
    n_vec++; if (digits !== 24'h543210) begin n_err++; $display("FAIL blink_clean_digits: got %h expected %h", digits, 24'h543210); end
  endtask
  task automatic test_recent;
    present(8'hFF, 7'h7F, 10);
    n_vec++; if (blink_field !== 2'd0) begin n_err++; $display("FAIL recent_sec: got %0d expected 0", blink_field); end
    for (int i = 1; i < 4; i++) show(i, 7, 8);
    present(8'hFF, 7'h7F, 10);
    n_vec++; if (blink_field !== 2'd2) begin n_err++; $display("FAIL recent_hour: got %0d expected 2", blink_field); end
    show(5, 7, 8);
    n_vec++; if (digits !== 24'h747770) begin n_err++; $display("FAIL recent_digits: got %h expected %h", digits, 24'h747770); end
  endtask
  task automatic test_reset_mid;
    show(0, 9, 2);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (digits !== 24'h0) begin n_err++; $display("FAIL midreset_digits: got %h expected %h", digits, 24'h0); end
    n_vec++; if (blink_field !== 2'd3) begin n_err++; $display("FAIL midreset_blink: got %0d expected 3", blink_field); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    repeat (SETTLE) @(posedge clk);
    #1;
    n_vec++; if (L_sec !== 4'd0) begin n_err++; $display("FAIL midreset_early: got %0d expected 0", L_sec); end
    @(posedge clk);
    #1;
    n_vec++; if (L_sec !== 4'd9) begin n_err++; $display("FAIL midreset_latency: got %0d expected 9", L_sec); end
    n_vec++; if (ce_n - ce0 + se_n - se0 + fd_n - fd0 !== 0) begin n_err++; $display("FAIL midreset_pulses: got %0d expected 0", ce_n - ce0 + se_n - se0 + fd_n - fd0); end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_errors();
    test_blink();
    test_recent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4: consecutive identical input samples required before a scan slot is accepted (legal range 2..15).
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 64: completed frames a blink indication is held after the last blanked slot (legal range 1..255).
REQ-003 Ports SHALL be as follows.
- clk_100MHz, input, 1: the single system clock; all logic rising-edge.
- rst_time, input, 1: asynchronous, active-low reset.
- bit_sel, input, 8: active-low digit enables. Bits 0..5 are L_sec, H_sec, L_min, H_min, L_hour, H_hour.
- seg_sel, input, 7: active-low segment code for the enabled digit.
- L_sec, H_sec, L_min, H_min, L_hour, H_hour, output, 4 each: last decoded BCD value per digit.
- frame_done, output, 1: one-cycle pulse when the H_hour slot is accepted.
- blink_field, output, 2: field currently blinking. 0 = sec, 1 = min, 2 = hour, 3 = none.
- code_err, output, 1: one-cycle pulse when an illegal segment code is accepted.
- sel_err, output, 1: one-cycle pulse when an illegal bit_sel pattern is accepted.

Function
REQ-004 bit_sel and seg_sel SHALL be registered once on entry; all decisions use the registered copies.
REQ-005 The FSM SHALL have states IDLE, SETTLING and CAPTURED.
- IDLE -> SETTLING on any change of {bit_sel, seg_sel}; the settle counter loads 1.
- SETTLING: the counter increments on each unchanged sample. When it reaches SETTLE, the state goes to CAPTURED and the sample is accepted. Any change restarts SETTLING with the counter at 1.
- CAPTURED -> SETTLING on any input change. Otherwise it holds, and no further acceptance occurs for the same pattern.
REQ-006 Classification of an accepted bit_sel:
- Exactly one of bits 0..5 low and bits 7:6 high: the digit slot with that index.
- 8'hFF: a blank slot.
- Anything else: illegal.
REQ-007 Digit slot: seg_sel SHALL be decoded with this table (active-low, bit 6 = g):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
REQ-008 A digit slot with a legal code SHALL update that digit's output on the cycle after acceptance (acceptance-to-output latency 1 cycle). The expected-slot pointer then becomes (index+1) mod 6.
REQ-009 A digit slot with a code not in the table SHALL pulse code_err. The digit output is left unchanged, but the pointer still advances.
REQ-010 A blank slot SHALL be attributed to the slot named by the expected-slot pointer. The pointer then advances mod 6, and no digit output changes.
REQ-011 An illegal bit_sel pattern SHALL pulse sel_err. No digit output changes and the pointer is left unchanged.
REQ-012 frame_done SHALL pulse for one cycle whenever slot 5 is accepted, either as a digit or as an attributed blank.
REQ-013 Blink tracking:
- A blank attributed to slot 0/1, 2/3 or 4/5 SHALL set blink_field to 0, 1 or 2 respectively.
- That blank SHALL also reload the hold counter with HOLD_FRAMES.
- Each frame_done decrements the hold counter (saturating at 0).
- blink_field returns to 3 when the counter reaches 0.
REQ-014 If blanks in different fields occur, the most recent attributed blank SHALL win.
REQ-015 Pointer wrap: after slot 5, the pointer SHALL equal 0. A digit slot always resynchronises the pointer to its own index+1.

Reset
REQ-016 While rst_time is low, the block SHALL hold these values, applied asynchronously:
- All digit outputs 0.
- frame_done, code_err and sel_err 0.
- blink_field 3.
- FSM in IDLE.
- Pointer 0.
- Settle counter 0, hold counter 0.
- Input registers 8'hFF and 7'h7F.
REQ-017 Reset asserted mid-settle or mid-hold SHALL discard partial state. After release, the first acceptance requires a full SETTLE run.

Verification
REQ-018 Scan: slots 0..5 presented with codes for 3,2,1,4,5,1, each held 100 cycles -> L_sec=3, H_sec=2, L_min=1, H_min=4, L_hour=5, H_hour=1; exactly one frame_done.
REQ-019 Glitch: a digit held for SETTLE-1 cycles between valid slots -> no output change, no error; the next stable slot is accepted normally.
REQ-020 Blink: frames with slots 2 and 3 replaced by 8'hFF -> blink_field=1 and minute digits retain prior values. After HOLD_FRAMES clean frames -> blink_field=3.
REQ-021 Errors:
- bit_sel=8'b11111100 held stable -> sel_err single pulse, outputs unchanged.
- seg_sel=7'b1111111 on slot 0 -> code_err single pulse, L_sec unchanged.
REQ-022 Reset: rst_time low mid-frame with blink_field=2 -> all outputs reach reset values immediately. After release, the first accepted slot takes SETTLE+1 cycles from the input change.
